// File: rtl/executor.sv
// executor: multi-cycle instruction executor that reads and writes an external register file over a shared tri-state bus.
// Defining EXECUTOR_MUL_EN adds the op 5 multiplier; without it op 5 is a NOP.
module executor #(
   parameter int N = 8,
   parameter int M = 2
) (
   input  logic           Clock,
   input  logic           ResetN,
   input  logic [19:0]    OpCode,
   output logic [M-1:0]   MemorySelect,
   inout  wire  [N-1:0]   MemoryData,
   output logic           MemoryRW,
   output logic [2*N-1:0] Output,
   output logic           SignFlag,
   output logic           ZeroFlag,
   output logic           Done
);
   localparam int W = 2 * N;

   // Handshake: Done=1 only in IDLE, and OpCode is sampled on every rising edge while Done=1.
   typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXE, S_WR} state_t;

   state_t         r_state, w_next;
   logic [3:0]     r_opc;
   logic [M-1:0]   r_rd, r_rs;
   logic [N-1:0]   r_imm, r_a, r_b;
   logic [W-1:0]   r_out;
   logic           r_zero, r_sign;

   logic [W-1:0]   w_a_x, w_b_x, w_result;
   logic [2:0]     w_shamt;
   logic           w_upd_out, w_upd_flags, w_wr_op;
   logic [N-1:0]   w_wdata;
   logic           w_unused_op;

   assign w_unused_op = &{1'b0, OpCode};
   assign w_a_x       = {{N{1'b0}}, r_a};
   assign w_b_x       = {{N{1'b0}}, r_b};
   assign w_shamt     = 3'(r_b);

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_state <= S_IDLE;
         r_opc   <= '0;
         r_rd    <= '0;
         r_rs    <= '0;
         r_imm   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_out   <= '0;
         r_zero  <= 1'b1;
         r_sign  <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               r_opc <= OpCode[19:16];
               r_rd  <= OpCode[12 +: M];
               r_rs  <= OpCode[8 +: M];
               r_imm <= OpCode[N-1:0];
            end
            S_RDA: r_a <= MemoryData;
            S_RDB: r_b <= MemoryData;
            S_EXE: begin
               if (w_upd_out) r_out <= w_result;
               if (w_upd_flags) begin
                  r_zero <= (w_result == '0);
                  r_sign <= w_result[W-1];
               end
            end
            default: ;
         endcase
      end
   end

   // CMP reuses the subtract path but only its flags are kept.
   always_comb begin
      w_result    = r_out;
      w_upd_out   = 1'b0;
      w_upd_flags = 1'b0;
      case (r_opc)
         4'h3: begin w_result = w_a_x + w_b_x;                        w_upd_out = 1'b1; w_upd_flags = 1'b1; end
         4'h4: begin w_result = w_a_x - w_b_x;                        w_upd_out = 1'b1; w_upd_flags = 1'b1; end
`ifdef EXECUTOR_MUL_EN
         4'h5: begin w_result = w_a_x * w_b_x;                        w_upd_out = 1'b1; w_upd_flags = 1'b1; end
`endif
         4'h6: begin w_result = w_a_x & w_b_x;                        w_upd_out = 1'b1; w_upd_flags = 1'b1; end
         4'h7: begin w_result = w_a_x | w_b_x;                        w_upd_out = 1'b1; w_upd_flags = 1'b1; end
         4'h8: begin w_result = w_a_x ^ w_b_x;                        w_upd_out = 1'b1; w_upd_flags = 1'b1; end
         4'h9: begin w_result = {{N{1'b0}}, ~r_a};                    w_upd_out = 1'b1; w_upd_flags = 1'b1; end
         4'hA: begin w_result = {{N{1'b0}}, r_a << w_shamt};          w_upd_out = 1'b1; w_upd_flags = 1'b1; end
         4'hB: begin w_result = {{N{1'b0}}, r_a >> w_shamt};          w_upd_out = 1'b1; w_upd_flags = 1'b1; end
         4'hC: begin w_result = w_a_x - w_b_x;                                          w_upd_flags = 1'b1; end
         4'hD: begin w_result = w_a_x;                                w_upd_out = 1'b1; w_upd_flags = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      w_wr_op = 1'b0;
      w_wdata = '0;
      case (r_opc)
         4'h1: begin w_wr_op = 1'b1; w_wdata = r_imm;          end
         4'h2: begin w_wr_op = 1'b1; w_wdata = r_b;            end
         4'hE: begin w_wr_op = 1'b1; w_wdata = r_out[N-1:0];   end
         default: ;
      endcase
   end

   always_comb begin
      w_next       = r_state;
      MemorySelect = '0;
      MemoryRW     = 1'b1;
      case (r_state)
         S_IDLE: w_next = S_RDA;
         S_RDA: begin MemorySelect = r_rd; w_next = S_RDB; end
         S_RDB: begin MemorySelect = r_rs; w_next = S_EXE; end
         S_EXE: w_next = S_WR;
         S_WR: begin
            w_next = S_IDLE;
            if (w_wr_op) begin
               MemorySelect = r_rd;
               MemoryRW     = 1'b0;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign MemoryData = MemoryRW ? {N{1'bz}} : w_wdata;
   assign Output     = r_out;
   assign ZeroFlag   = r_zero;
   assign SignFlag   = r_sign;
   assign Done       = (r_state == S_IDLE);
endmodule

// File: tb/tb_executor.sv
// Bench for executor: register-file companion memory, directed scenarios, then random opcodes against a reference model.
module tb_executor;
  localparam int N = 8;
  localparam int M = 2;

  logic          Clock;
  logic          ResetN;
  logic [19:0]   OpCode;
  logic [M-1:0]  MemorySelect;
  wire  [N-1:0]  MemoryData;
  logic          MemoryRW;
  logic [2*N-1:0] Output;
  logic          SignFlag;
  logic          ZeroFlag;
  logic          Done;

  executor #(.N(N), .M(M)) dut (
    .Clock(Clock), .ResetN(ResetN), .OpCode(OpCode),
    .MemorySelect(MemorySelect), .MemoryData(MemoryData), .MemoryRW(MemoryRW),
    .Output(Output), .SignFlag(SignFlag), .ZeroFlag(ZeroFlag), .Done(Done)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // companion register-file memory
  logic [N-1:0] mem [4];
  assign MemoryData = MemoryRW ? mem[MemorySelect] : {N{1'bz}};
  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else if (!MemoryRW) begin
      mem[MemorySelect] <= MemoryData;
    end
  end

  // reference model state
  int ref_mem [4];
  int ref_out;
  int ref_z;
  int ref_s;
  int n_pass;
  int n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_mem[i] = 0;
    ref_out = 0;
    ref_z = 1;
    ref_s = 0;
  endtask

  task automatic set_out(input int v);
    ref_out = v & 'hFFFF;
    ref_z = (ref_out == 0);
    ref_s = (ref_out >= 'h8000);
  endtask

  task automatic model(input logic [19:0] op);
    int o, rd, rs, a, b, imm, d;
    o   = int'(op[19:16]);
    rd  = int'(op[13:12]);
    rs  = int'(op[9:8]);
    imm = int'(op[7:0]);
    a = ref_mem[rd];
    b = ref_mem[rs];
    case (o)
      1:  ref_mem[rd] = imm;
      2:  ref_mem[rd] = b;
      3:  set_out(a + b);
      4:  set_out(a - b);
`ifdef EXECUTOR_MUL_EN
      5:  set_out(a * b);
`endif
      6:  set_out(a & b);
      7:  set_out(a | b);
      8:  set_out(a ^ b);
      9:  set_out(255 - a);
      10: set_out((a << (b % 8)) % 256);
      11: set_out(a >> (b % 8));
      12: begin
        d = (a - b) & 'hFFFF;
        ref_z = (d == 0);
        ref_s = (d >= 'h8000);
      end
      13: set_out(a);
      14: ref_mem[rd] = ref_out % 256;
      default: ;
    endcase
  endtask

  // driver: called at a falling edge while Done=1; returns at the falling edge where Done is back high
  task automatic exec(input logic [19:0] op);
    int lo;
    OpCode = op;
    lo = 0;
    do begin
      @(negedge Clock);
      if (!Done) lo++;
    end while (!Done && lo < 10);
    chk("done_low_cycles", lo, 4);
    model(op);
    chk("output", Output, ref_out);
    chk("zero_flag", ZeroFlag, ref_z);
    chk("sign_flag", SignFlag, ref_s);
    for (int i = 0; i < 4; i++) chk("mem", mem[i], ref_mem[i]);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    ResetN = 1'b0;
    OpCode = 20'h0;
    model_reset();
    #12;
    chk("rst_done", Done, 1);
    chk("rst_output", Output, 0);
    chk("rst_zero", ZeroFlag, 1);
    chk("rst_sign", SignFlag, 0);
    chk("rst_rw", MemoryRW, 1);
    chk("rst_select", MemorySelect, 0);
    for (int i = 0; i < 4; i++) chk("rst_mem", mem[i], 0);
    @(negedge Clock);
    ResetN = 1'b1;

    exec(20'h10012);            // LOAD r0,0x12
    exec(20'h11034);            // LOAD r1,0x34
    exec(20'h30100);            // ADD r0,r1
    chk("add_out", Output, 16'h0046);
    chk("add_z", ZeroFlag, 0);
    chk("add_s", SignFlag, 0);
    exec(20'h40100);            // SUB r0,r1
    chk("sub_out", Output, 16'hFFDE);
    chk("sub_s", SignFlag, 1);
    chk("sub_z", ZeroFlag, 0);
    exec(20'hC0000);            // CMP r0,r0
    chk("cmp_z", ZeroFlag, 1);
    chk("cmp_out", Output, 16'hFFDE);
    exec(20'h120FF);            // LOAD r2,0xFF
    exec(20'h52200);            // MUL r2,r2
`ifdef EXECUTOR_MUL_EN
    chk("mul_out", Output, 16'hFE01);
`else
    chk("mul_out", Output, 16'hFFDE);
`endif
    exec(20'h30100);            // ADD r0,r1
    exec(20'hE3000);            // WB r3
    exec(20'hD3000);            // OUT r3
    chk("out_r3", Output, 16'h0046);
    chk("wb_mem3", mem[3], 8'h46);

    // reset during EXE of LOAD r0,0x55
    OpCode = 20'h10055;
    @(posedge Clock);
    @(posedge Clock);
    @(posedge Clock);
    #2 ResetN = 1'b0;
    #1;
    chk("abort_done", Done, 1);
    chk("abort_output", Output, 0);
    chk("abort_rw", MemoryRW, 1);
    #10;
    OpCode = 20'h0;
    model_reset();
    @(negedge Clock);
    ResetN = 1'b1;
    chk("abort_mem0", mem[0], 0);
    exec(20'h00000);

    // random opcodes; field bits above M exercise register-field truncation
    for (int k = 0; k < 60; k++) exec(20'($urandom()));
    // bias toward memory-writing and arithmetic ops with random fields
    for (int k = 0; k < 30; k++) begin
      logic [19:0] op;
      op = 20'($urandom());
      op[19:16] = 4'($urandom_range(1, 5));
      exec(op);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
